mr_index_split: RTL and testbench

//  Splits a linear binary input-buffer index into NDIG mixed-radix digits, digit k in 0..radix_k-1.
//  It is the inverse of the modular-adder digit chain: that chain builds mixed-radix addresses, and this block decomposes them.

---
 rtl/mr_index_split.sv | 123 ++++++++++++
 tb/tb_mr_index_split.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mr_index_split.sv
// Mixed-radix index splitter: decomposes a linear index into NDIG digits by
// repeated subtraction, one digit stage at a time, behind a start/busy/done handshake.
module mr_index_split #(
  parameter int NDIG    = 3,
  parameter int DW      = 2,
  parameter int RADIX_W = 3,
  parameter int IDX_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IDX_W-1:0]        idx,
  input  logic [NDIG*RADIX_W-1:0] radix,
  output logic                    busy,
  output logic                    done,
  output logic [NDIG*DW-1:0]      digits,
  output logic                    ovf,
  output logic                    err
);

  localparam int K_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int RMAX = 1 << DW;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     rem, quot;
  logic [K_W-1:0]       k;
  logic [RADIX_W-1:0]   rad [NDIG];
  logic [IDX_W-1:0]     r_cur;
  logic                 radix_bad;
  logic                 rem_lt;
  logic                 last;
  logic [NDIG*DW-1:0]   digits_q;
  logic                 ovf_q, err_q;

  // Any radix outside 2..2**DW makes the request unanswerable.
  always_comb begin
    radix_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (int'(radix[i*RADIX_W +: RADIX_W]) < 2 ||
          int'(radix[i*RADIX_W +: RADIX_W]) > RMAX)
        radix_bad = 1'b1;
    end
  end

  assign r_cur  = IDX_W'(rad[k]);
  assign rem_lt = rem < r_cur;
  assign last   = (k == K_W'(NDIG-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = radix_bad ? DONE : DIV;
      DIV:     if (rem_lt && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // When the remainder drops below the radix, it is the digit and the quotient
  // becomes the dividend for the next, more significant stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      quot     <= '0;
      k        <= '0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NDIG; i++) rad[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (radix_bad) begin
              err_q    <= 1'b1;
              ovf_q    <= 1'b0;
              digits_q <= '0;
            end else begin
              rem   <= idx;
              quot  <= '0;
              k     <= '0;
              err_q <= 1'b0;
              ovf_q <= 1'b0;
              for (int i = 0; i < NDIG; i++) rad[i] <= radix[i*RADIX_W +: RADIX_W];
            end
          end
        end
        DIV: begin
          if (!rem_lt) begin
            rem  <= rem - r_cur;
            quot <= quot + IDX_W'(1);
          end else begin
            for (int i = 0; i < NDIG; i++) begin
              if (K_W'(i) == k) digits_q[i*DW +: DW] <= rem[DW-1:0];
            end
            if (last) begin
              ovf_q <= (quot != '0);
            end else begin
              rem  <= quot;
              quot <= '0;
              k    <= k + K_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign digits = digits_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mr_index_split.sv
// Scoreboard bench for mr_index_split: expected digits/flags/latency come from a
// division-based reference model and are popped when done pulses.
module tb_mr_index_split;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] idx;
  logic [8:0] radix;
  logic       busy, done, ovf, err;
  logic [5:0] digits;

  typedef struct {
    logic [5:0] dig;
    logic       ovf;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  mr_index_split #(.NDIG(3), .DW(2), .RADIX_W(3), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .idx(idx), .radix(radix),
    .busy(busy), .done(done), .digits(digits), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input int ix, input logic [8:0] rv);
    exp_t e;
    int   q, rk, prod;
    bit   bad;
    bad = 0;
    for (int j = 0; j < 3; j++) begin
      rk = int'(rv[j*3 +: 3]);
      if (rk < 2 || rk > 4) bad = 1;
    end
    e.dig = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1;
    if (bad) begin
      e.err = 1'b1;
      return e;
    end
    q = ix; prod = 1;
    for (int j = 0; j < 3; j++) begin
      rk = int'(rv[j*3 +: 3]);
      e.dig[j*2 +: 2] = 2'(q % rk);
      e.lat += q / rk + 1;
      q = q / rk;
      prod *= rk;
    end
    e.ovf = (ix >= prod);
    return e;
  endfunction

  task automatic applyStimulus(input logic [7:0] ix, input logic [8:0] rv, input bit noise);
    exp_t e;
    int   cyc;
    bit   got;
    @(negedge clk);
    idx = ix; radix = rv; start = 1'b1;
    sb.push_back(model(int'(ix), rv));
    @(posedge clk);
    #1;
    start = 1'b0; idx = 8'($urandom); radix = 9'($urandom);
    cyc = 0; got = 0;
    while (!got && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput("busy_c1", busy, 1);
      if (done) begin
        got = 1;
        e = sb.pop_front();
        checkOutput("digits", 32'(digits), 32'(e.dig));
        checkOutput("ovf", ovf, e.ovf);
        checkOutput("err", err, e.err);
        checkOutput("latency", cyc, e.lat);
      end else if (noise) begin
        start = 1'($urandom_range(0, 1)); idx = 8'($urandom); radix = 9'($urandom);
      end
    end
    start = 1'b0;
    if (!got) begin
      checkOutput("timeout", got, 1);
      sb.delete();
    end
    @(negedge clk);
    checkOutput("done_pulse", done, 0);
    checkOutput("busy_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; idx = '0; radix = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_digits", 32'(digits), 0);

    applyStimulus(8'd23, {3'd2, 3'd4, 3'd3}, 0);
    applyStimulus(8'd24, {3'd2, 3'd4, 3'd3}, 0);
    applyStimulus(8'd0,  {3'd4, 3'd4, 3'd4}, 0);
    applyStimulus(8'd77, {3'd2, 3'd1, 3'd3}, 0);
    applyStimulus(8'd77, {3'd2, 3'd5, 3'd3}, 0);
    applyStimulus(8'd9,  {3'd7, 3'd2, 3'd0}, 0);
    applyStimulus(8'd23, {3'd2, 3'd4, 3'd3}, 1);
    applyStimulus(8'd255, {3'd4, 3'd4, 3'd4}, 0);

    // Abort mid-DIV after a run that left nonzero digits.
    applyStimulus(8'd23, {3'd2, 3'd4, 3'd3}, 0);
    @(negedge clk);
    idx = 8'd200; radix = {3'd4, 3'd4, 3'd4}; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_ovf", ovf, 0);
    checkOutput("abort_err", err, 0);
    checkOutput("abort_digits", 32'(digits), 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_quiet", done, 0);
    end
    applyStimulus(8'd100, {3'd3, 3'd3, 3'd4}, 0);

    for (int n = 0; n < 30; n++) begin
      applyStimulus(8'($urandom_range(0, 255)),
                    {3'($urandom_range(2, 4)), 3'($urandom_range(2, 4)), 3'($urandom_range(2, 4))},
                    1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
